uart_rx: RTL and testbench

Serial receiver that consumes the 8N1 line produced by the `uart_tx` stage and recovers parallel bytes. It samples the asynchronous `rx_in` line through a two-flop synchronizer. Each bit is timed from an internal per-bit counter clocked by the system clock, with no dependence on `baud_gen`. Each received byte is presented on `data_out` with a one-cycle `data_valid` strobe; a bad stop bit raises a one-cycle `frame_err`.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 115 +++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and the receiver state encoding.
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } uart_state_e;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; INIT sets the reset value of both flops.
module uart_sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= INIT;
      q  <= INIT;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling timed by a per-bit counter, registered byte/strobe outputs.
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  logic          rx_sync;
  uart_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          dv_n, fe_n;

  uart_sync2 #(.INIT(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_sync)
  );

  wire half_hit = (cnt == CW'(HALF - 1));
  wire bit_hit  = (cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data_out;
    dv_n      = 1'b0;
    fe_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = ST_START;
      end
      ST_START: begin
        if (half_hit) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // A start bit that is high again at its midpoint was only a glitch.
          state_n   = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'(UART_DATA_BITS - 1)) state_n = ST_STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          cnt_n = '0;
          if (rx_sync) begin
            data_n  = shreg;
            dv_n    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = ST_RECOVER;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_RECOVER: begin
        // Hold off until the line returns high so a break cannot look like a start bit.
        cnt_n = '0;
        if (rx_sync) state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      data_out   <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
      busy       <= (state_n != ST_IDLE);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames bit-accurately and checks strobes, bytes and timing against a frame-level model.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  typedef struct {
    int         cyc;
    logic       fe;
    logic [7:0] b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;
  int run = 0, max_run = 0;
  bit track = 1'b0;
  logic [7:0] last_good = 8'h00;
  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Record every strobe with the cycle of the edge that raised it.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (data_valid && frame_err) overlap++;
    if (data_valid || frame_err) begin
      e.cyc = cyc;
      e.fe  = frame_err;
      e.b   = data_out;
      obs_q.push_back(e);
    end
    if (!track) run = 0;
    else if (!busy) run++;
    else begin
      if (run > max_run) max_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; a low stop bit leaves the line low for hold_low extra clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_low);
    ev_t e;
    e.cyc = cyc + 1 + LAT;
    e.fe  = ~stop;
    e.b   = stop ? b : last_good;
    if (stop) last_good = b;
    exp_q.push_back(e);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
    if (!stop) tick(hold_low);
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cyc"},  obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_kind"}, {31'd0, obs_q[i].fe}, {31'd0, exp_q[i].fe});
      chk({tag, "_byte"}, {24'd0, obs_q[i].b}, {24'd0, exp_q[i].b});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] tartz [5];
    tartz = '{8'h54, 8'h61, 8'h72, 8'h74, 8'h7A};
    rx_in = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("rst_data",  {24'd0, data_out}, 32'h0);
    chk("rst_valid", {31'd0, data_valid}, 32'h0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(3);

    send_frame(8'h54, 1'b1, 0);
    tick(20);
    check_events("single");
    chk("single_data", {24'd0, data_out}, 32'h54);

    track = 1'b1;
    foreach (tartz[i]) send_frame(tartz[i], 1'b1, 0);
    track = 1'b0;
    tick(20);
    check_events("stream");
    chk("busy_gap", {31'd0, (max_run <= 8 && max_run > 0)}, 32'h1);

    rx_in = 1'b0;
    tick(5);
    rx_in = 1'b1;
    tick(20);
    chk("glitch_busy", {31'd0, busy}, 32'h0);
    check_events("glitch");
    send_frame(8'hA5, 1'b1, 0);
    tick(20);
    check_events("after_glitch");

    send_frame(8'h3C, 1'b0, 40);
    chk("recover_busy", {31'd0, busy}, 32'h1);
    rx_in = 1'b1;
    tick(200);
    chk("recover_exit", {31'd0, busy}, 32'h0);
    chk("ferr_hold", {24'd0, data_out}, 32'hA5);
    check_events("frame_err");
    send_frame(8'hC3, 1'b1, 0);
    tick(20);
    check_events("after_ferr");

    rx_in = 1'b0;
    tick(CPB);
    rx_in = 1'b1;
    tick(4 * CPB + HALF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data",  {24'd0, data_out}, 32'h0);
    chk("async_valid", {31'd0, data_valid}, 32'h0);
    chk("async_ferr",  {31'd0, frame_err}, 32'h0);
    chk("async_busy",  {31'd0, busy}, 32'h0);
    last_good = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(CPB * 6);
    check_events("midreset");
    send_frame(8'h0F, 1'b1, 0);
    tick(20);
    check_events("after_reset");
    chk("after_reset_data", {24'd0, data_out}, 32'h0F);

    for (int f = 0; f < 10; f++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) begin
        rx_in = 1'b0;
        tick($urandom_range(6, 1));
        rx_in = 1'b1;
        tick(12);
      end
      send_frame(b, stop, stop ? 0 : $urandom_range(30));
      rx_in = 1'b1;
      tick(stop ? $urandom_range(20) : $urandom_range(20, 3));
    end
    tick(200);
    check_events("random");
    chk("no_overlap", overlap, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
